// File: rtl/hatch_loader.sv
// hatch_loader: assembles a big-endian byte stream into 48-bit instruction words and releases the CPU.
// Define HATCH_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte (CHK/ERR states).
module hatch_loader #(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic [31:0] hatch_address,
    output logic [47:0] hatch_instruction,
    output logic        cpu_rst_b,
    output logic        load_done,
    output logic        load_err
);
    typedef enum logic [2:0] {
        LEN_HI, LEN_LO, DATA,
`ifdef HATCH_LOADER_CHECKSUM_EN
        CHK, ERR,
`endif
        RUN
    } state_t;
`ifdef HATCH_LOADER_CHECKSUM_EN
    localparam state_t FIN = CHK;
`else
    localparam state_t FIN = RUN;
`endif
    localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;
    state_t state, state_n;
    logic [15:0] len, wp;
    logic [2:0] cnt;
    logic [39:0] shift;
    logic [47:0] mem [0:(1<<ADDR_W)-1];
    logic acc, last_byte, fits;
`ifdef HATCH_LOADER_CHECKSUM_EN
    logic [7:0] xsum;
    assign in_ready = state != RUN && state != ERR;
`else
    assign in_ready = state != RUN;
`endif
    assign acc = in_valid && in_ready;
    assign last_byte = cnt == 3'd5;
    assign fits = {1'b0, wp} < DEPTH;
    assign hatch_instruction = (hatch_address >> ADDR_W) == 32'd0 ? mem[hatch_address[ADDR_W-1:0]] : 48'h0;
    always_comb begin
        state_n = state;
        if (acc)
            case (state)
                LEN_HI:  state_n = LEN_LO;
                LEN_LO:  state_n = {len[15:8], in_data} != 16'd0 ? DATA : FIN;
                DATA:    state_n = last_byte && wp == len - 16'd1 ? FIN : DATA;
`ifdef HATCH_LOADER_CHECKSUM_EN
                CHK:     state_n = in_data == xsum ? RUN : ERR;
`endif
                default: state_n = state;
            endcase
    end
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= LEN_HI;
            len       <= '0;
            wp        <= '0;
            cnt       <= '0;
            shift     <= '0;
            cpu_rst_b <= 1'b0;
            load_done <= 1'b0;
        end else begin
            state     <= state_n;
            cpu_rst_b <= state_n == RUN;
            load_done <= state_n == RUN;
            if (acc && state == LEN_HI) len[15:8] <= in_data;
            if (acc && state == LEN_LO) len[7:0] <= in_data;
            if (acc && state == DATA) begin
                cnt   <= last_byte ? 3'd0 : cnt + 3'd1;
                wp    <= last_byte ? wp + 16'd1 : wp;
                shift <= last_byte ? shift : {shift[31:0], in_data};
            end
        end
    end
    // Words beyond the array are counted in wp but never written, so memory cannot wrap.
    always_ff @(posedge clk) begin
        if (acc && state == DATA && last_byte && fits) mem[wp[ADDR_W-1:0]] <= {shift, in_data};
    end
`ifdef HATCH_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            xsum     <= '0;
            load_err <= 1'b0;
        end else begin
            load_err <= state_n == ERR;
            if (acc && state != CHK) xsum <= xsum ^ in_data;
        end
    end
`else
    assign load_err = 1'b0;
`endif
endmodule

// File: tb/tb_hatch_loader.sv
// tb_hatch_loader: directed loads on a 1024-word and a 4-word instance, checked through an expectation queue.
module tb_hatch_loader;
    logic clk = 1'b0;
    logic rst_a = 1'b0, rst_b2 = 1'b0;
    logic valid_a = 1'b0, valid_b = 1'b0;
    logic [7:0] data_a = '0, data_b = '0;
    logic [31:0] addr_a = '0, addr_b = '0;
    logic ready_a, ready_b, crst_a, crst_b, done_a, done_b, err_a, err_b;
    logic [47:0] instr_a, instr_b;

    hatch_loader #(.ADDR_W(10)) dut_a (
        .clk(clk), .rst_b(rst_a), .in_valid(valid_a), .in_data(data_a), .in_ready(ready_a),
        .hatch_address(addr_a), .hatch_instruction(instr_a), .cpu_rst_b(crst_a),
        .load_done(done_a), .load_err(err_a));
    hatch_loader #(.ADDR_W(2)) dut_b (
        .clk(clk), .rst_b(rst_b2), .in_valid(valid_b), .in_data(data_b), .in_ready(ready_b),
        .hatch_address(addr_b), .hatch_instruction(instr_b), .cpu_rst_b(crst_b),
        .load_done(done_b), .load_err(err_b));

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [47:0] val;
        string       name;
    } exp_t;
    exp_t q[$];
    exp_t e;
    logic [47:0] act;
    int n_cmp = 0, n_bad = 0;
    logic [47:0] words [0:7];

    // kind: 0 status A, 1 instruction A, 2 status B, 3 instruction B; status = {in_ready, cpu_rst_b, load_done, load_err}
    always @(negedge clk) begin
        while (q.size() > 0) begin
            e = q.pop_front();
            act = e.kind == 0 ? {44'b0, ready_a, crst_a, done_a, err_a} :
                  e.kind == 1 ? instr_a :
                  e.kind == 2 ? {44'b0, ready_b, crst_b, done_b, err_b} : instr_b;
            n_cmp++;
            if (act !== e.val) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.val);
            end
        end
    end

    task automatic expect_status(input bit sel, input logic [3:0] s, input string name);
        q.push_back('{sel ? 2 : 0, {44'b0, s}, name});
    endtask

    task automatic read(input bit sel, input logic [31:0] a, input logic [47:0] w, input string name);
        if (sel) addr_b = a; else addr_a = a;
        q.push_back('{sel ? 3 : 1, w, name});
        @(negedge clk);
        #1;
    endtask

    task automatic send(input bit sel, input logic [7:0] b);
        if (sel) begin valid_b = 1'b1; data_b = b; end
        else begin valid_a = 1'b1; data_a = b; end
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    task automatic idle(input bit sel, input int c);
        for (int i = 0; i < c; i++) begin
            if (sel) data_b = 8'($urandom); else data_a = 8'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_dut(input bit sel, input string name);
        if (sel) rst_b2 = 1'b0; else rst_a = 1'b0;
        expect_status(sel, 4'b1000, name);
        repeat (2) @(posedge clk);
        #1;
        if (sel) rst_b2 = 1'b1; else rst_a = 1'b1;
    endtask

    task automatic load(input bit sel, input int n, input bit gaps, input bit bad_chk, input string name);
        logic [7:0] b[$];
        logic [7:0] x;
        x = 8'h00;
        b.push_back(8'(n >> 8));
        b.push_back(8'(n));
        for (int i = 0; i < n; i++)
            for (int k = 5; k >= 0; k--) b.push_back(words[i][k*8 +: 8]);
        foreach (b[i]) x ^= b[i];
`ifdef HATCH_LOADER_CHECKSUM_EN
        b.push_back(bad_chk ? x ^ 8'h01 : x);
`endif
        for (int i = 0; i < b.size(); i++) begin
            if (gaps) idle(sel, i == 3 ? 10 : int'($urandom_range(2, 0)));
            if (i == b.size() - 1) expect_status(sel, 4'b1000, {name, "_held"});
            send(sel, b[i]);
        end
        expect_status(sel, bad_chk ? 4'b0001 : 4'b0110, {name, "_release"});
    endtask

    initial begin
        reset_dut(0, "reset_a");
        words[0] = 48'h0123456789AB;
        words[1] = 48'hFEDCBA987654;
        load(0, 2, 0, 0, "cont");
        read(0, 32'd0, 48'h0123456789AB, "cont_w0");
        read(0, 32'd1, 48'hFEDCBA987654, "cont_w1");
        read(0, 32'h400, 48'h0, "oob_400");
        read(0, 32'h1000, 48'h0, "oob_1000");
        send(0, 8'h55);
        expect_status(0, 4'b0110, "run_ignores_byte");
        read(0, 32'd0, 48'h0123456789AB, "run_w0_kept");
        reset_dut(0, "async_reset_in_run");
        for (int i = 0; i < 5; i++) send(0, i == 1 ? 8'h02 : 8'h77);
        reset_dut(0, "async_reset_midload");
        words[0] = 48'hA0A1A2A3A4A5;
        words[1] = 48'hB0B1B2B3B4B5;
        load(0, 2, 0, 0, "after_abort");
        read(0, 32'd0, 48'hA0A1A2A3A4A5, "abort_w0");
        read(0, 32'd1, 48'hB0B1B2B3B4B5, "abort_w1");
        reset_dut(0, "reset_gap");
        words[0] = 48'h0123456789AB;
        words[1] = 48'hFEDCBA987654;
        load(0, 2, 1, 0, "gapped");
        read(0, 32'd0, 48'h0123456789AB, "gap_w0");
        read(0, 32'd1, 48'hFEDCBA987654, "gap_w1");
        reset_dut(0, "reset_n0");
        load(0, 0, 0, 0, "n0");
        read(0, 32'h1000, 48'h0, "n0_oob");
        reset_dut(1, "reset_b");
        words[0] = 48'h111111111111;
        words[1] = 48'h222222222222;
        words[2] = 48'h333333333333;
        words[3] = 48'h444444444444;
        words[4] = 48'h555555555555;
        load(1, 5, 0, 0, "ovf");
        read(1, 32'd0, 48'h111111111111, "ovf_w0");
        read(1, 32'd1, 48'h222222222222, "ovf_w1");
        read(1, 32'd2, 48'h333333333333, "ovf_w2");
        read(1, 32'd3, 48'h444444444444, "ovf_w3");
        read(1, 32'd4, 48'h0, "ovf_oob4");
`ifdef HATCH_LOADER_CHECKSUM_EN
        reset_dut(0, "reset_chk");
        words[0] = 48'hDEADBEEFCAFE;
        load(0, 1, 0, 1, "badchk");
        idle(0, 3);
        expect_status(0, 4'b0001, "err_sticky");
        send(0, 8'h00);
        expect_status(0, 4'b0001, "err_ignores_byte");
        reset_dut(0, "err_cleared");
`endif
        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hatch_loader.md
# hatch_loader

Boot-time instruction store that sits directly upstream of the CPU fetch stage. It receives a byte stream from the host link and assembles it into 48-bit instruction words in a local instruction memory. It holds the CPU in reset until loading completes, then serves fetch requests on the hatch interface (`hatch_address` in, `hatch_instruction` out).

## Interface
- `ADDR_W`, default 10: instruction memory index width; depth is 2^ADDR_W words.
- `clk` input, 1 bit: system clock; all state changes on the rising edge.
- `rst_b` input, 1 bit: one clock; reset is asynchronous and active-low.
- `in_valid` input, 1 bit: byte on `in_data` is valid.
- `in_data` input, 8 bits: stream byte.
- `in_ready` output, 1 bit: loader accepts a byte this cycle.
- `hatch_address` input, 32 bits: fetch word address from the CPU.
- `hatch_instruction` output, 48 bits: instruction at `hatch_address`.
- `cpu_rst_b` output, 1 bit: active-low reset to the CPU; registered.
- `load_done` output, 1 bit: image loaded and CPU released; registered.
- `load_err` output, 1 bit: checksum failure. Tied 0 when the checksum feature is compiled out.

## Operation
- A byte is accepted on a rising edge when `in_valid && in_ready`.
- Stream format, big-endian throughout:
  - LEN_HI byte, then LEN_LO byte, forming the 16-bit word count N.
  - N×6 data bytes; each word is sent MSB byte first (bits 47:40 first).
  - Optional checksum byte (see Configuration).
- FSM states: LEN_HI, LEN_LO, DATA, CHK, RUN, ERR.
  - LEN_HI → LEN_LO on accept.
  - LEN_LO → DATA on accept if N>0. If N=0, go to CHK when the checksum is compiled in, else RUN.
  - DATA: a 3-bit byte counter runs 0..5. A 40-bit shift register collects bytes 0..4. On accepting byte 5, the word {shift, byte} is written to memory at word pointer wp, wp increments, and the byte counter returns to 0. After the Nth word the FSM leaves DATA: to CHK when the checksum is compiled in, else RUN.
  - RUN and ERR are terminal until `rst_b`.
- Words with wp ≥ 2^ADDR_W are accepted and counted but not written; the memory never wraps.
- `wp` is 16 bits, so a full 65535-word count is tracked without overflow.
- `in_ready` = 1 in LEN_HI, LEN_LO, DATA and CHK; 0 in RUN and ERR.
- Read path is combinational from the memory array. It returns `mem[hatch_address[ADDR_W-1:0]]` when `hatch_address[31:ADDR_W]` == 0, else 48'h0.
- Reads are valid in every state. During loading they return current contents; the CPU is held in reset, so this is harmless.
- Memory is not cleared by reset. Locations not written since power-up are undefined in hardware and X in simulation.

## Timing
- Reset values: `in_ready`=1 (state LEN_HI), `cpu_rst_b`=0, `load_done`=0, `load_err`=0, wp=0, byte counter=0, shift register=0.
- Asynchronous reset mid-load returns to LEN_HI immediately. Partially loaded words remain in memory but will be overwritten by the next load.
- Word write occurs on the same edge that accepts its 6th byte. It is visible on `hatch_instruction` combinationally from the following cycle.
- `cpu_rst_b` and `load_done` rise on the edge that moves the FSM into RUN: the edge accepting the final data byte, LEN_LO (when N=0), or the checksum byte.
- The CPU's first fetch is therefore at least one cycle after the last write; no read/write hazard exists.
- `in_valid` may drop mid-word for any number of cycles. Collected bytes and counters hold.
- `in_data` is ignored when `in_valid`=0 or `in_ready`=0.

## Configuration
- `HATCH_LOADER_CHECKSUM_EN` defined:
  - An 8-bit running XOR covers all bytes from LEN_HI through the last data byte.
  - State CHK accepts one byte. If it equals the running XOR, go to RUN. Otherwise go to ERR, with `load_err`=1, `cpu_rst_b`=0 and `in_ready`=0 until reset.
- `HATCH_LOADER_CHECKSUM_EN` not defined:
  - No CHK/ERR states and no checksum byte.
  - `load_err` is constant 0.
  - Loading ends after the last data byte.

## Test plan
- Reset: hold `rst_b`=0 → `cpu_rst_b`=0, `load_done`=0, `in_ready`=1. Release, then assert mid-load → FSM back to LEN_HI the same instant.
- Load N=2 words 48'h0123456789AB and 48'hFEDCBA987654, continuous `in_valid` (plus checksum 0x02^... when enabled) → `hatch_address`=0 returns 48'h0123456789AB, `hatch_address`=1 returns 48'hFEDCBA987654. `cpu_rst_b` rises on the edge after the final byte; `in_ready`=0 thereafter.
- Same load with `in_valid` toggled randomly, including 10-cycle gaps between bytes 2 and 3 → identical memory contents and release timing relative to the last accepted byte.
- N=0 (no checksum) → RUN entered on the LEN_LO edge. `hatch_address`=32'h0000_1000 (ADDR_W=10) returns 48'h0.
- Overflow with ADDR_W=2 and N=5 → words 0..3 stored, word 4 discarded, reading address 0 still returns word 0, and `load_done`=1 after 30 data bytes.
- With `HATCH_LOADER_CHECKSUM_EN`: correct checksum → RUN. Corrupted checksum (XOR^0x01) → `load_err`=1, `cpu_rst_b` stays 0, and `in_ready`=0 until `rst_b` pulses.
